// File: rtl/noc_pkg.sv
// Shared flit layout, scheduler constants and the scheduler FSM state type.
package noc_pkg;

  localparam int N_VC     = 3;
  localparam int FLIT_W   = 37;
  localparam int VLD_BIT  = 0;
  localparam int VC_LSB   = 1;
  localparam int VC_MSB   = 2;
  localparam int DATA_LSB = 3;
  localparam int DATA_W   = FLIT_W - DATA_LSB;
  localparam int CRED_W   = 3;

  typedef struct packed {
    logic [DATA_W-1:0]      data;
    logic [VC_MSB:VC_LSB]   vc_id;
    logic                   vld;
  } flit_t;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } sched_state_t;

endpackage

// File: rtl/vc_output_scheduler_if.sv
// Bundle between the per-VC buffers, the credit return path and the output scheduler.
interface vc_output_scheduler_if #(
  parameter int NV = noc_pkg::N_VC,
  parameter int FW = noc_pkg::FLIT_W
);

  logic [NV*FW-1:0]             vc_req_i;
  logic [NV-1:0]                vc_ready_o;
  logic [FW-1:0]                fout_req_o;
  logic [NV-1:0]                credit_ret_i;
  logic [NV*noc_pkg::CRED_W-1:0] credit_cnt_o;
  logic                         credit_err_o;
  noc_pkg::sched_state_t        state_o;

  modport master (
    output vc_req_i, credit_ret_i,
    input  vc_ready_o, fout_req_o, credit_cnt_o, credit_err_o, state_o
  );

  modport slave (
    input  vc_req_i, credit_ret_i,
    output vc_ready_o, fout_req_o, credit_cnt_o, credit_err_o, state_o
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins, wrapping mod N.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);

  logic [PW:0] idx;
  logic        found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      // Explicit wrap: N need not be a power of two.
      idx = {1'b0, ptr} + (PW+1)'(i);
      if (idx >= (PW+1)'(N)) begin
        idx = idx - (PW+1)'(N);
      end
      if (!found && req[idx[PW-1:0]]) begin
        grant[idx[PW-1:0]] = 1'b1;
        found              = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vc_output_scheduler.sv
// Credit-aware round-robin scheduler from N_VC buffers onto one registered output link.
// Define VC_SCHED_LOCK_EN to let a VC hold the link for bursts of up to BURST_LEN flits.
module vc_output_scheduler #(
  parameter int N_VC      = noc_pkg::N_VC,
  parameter int FLIT_W    = noc_pkg::FLIT_W,
  parameter int BUF_DEPTH = 4
`ifdef VC_SCHED_LOCK_EN
  , parameter int BURST_LEN = 4
`endif
) (
  input  logic                  clk,
  input  logic                  arst,
  vc_output_scheduler_if.slave  bus
);
  import noc_pkg::*;

  localparam int PTR_W = (N_VC > 1) ? $clog2(N_VC) : 1;
  localparam int PAY_W = FLIT_W - DATA_LSB;
  localparam int VC_W  = VC_MSB - VC_LSB + 1;

  logic [N_VC-1:0]              eligible;
  logic [N_VC-1:0]              rr_grant;
  logic [N_VC-1:0]              sel_grant;
  logic [N_VC-1:0]              grant;
  logic                         grant_any;
  logic [PTR_W-1:0]             grant_idx;
  logic [PAY_W-1:0]             pay_sel;
  logic [N_VC-1:0][CRED_W-1:0]  credit_q, credit_d;
  logic [PTR_W-1:0]             ptr_q, ptr_d;
  logic [FLIT_W-1:0]            fout_q, fout_d;
  logic                         err_q, err_d;
  sched_state_t                 state_q, state_d;

  always_comb begin
    for (int k = 0; k < N_VC; k++) begin
      eligible[k] = bus.vc_req_i[k*FLIT_W + VLD_BIT] && (credit_q[k] != '0);
    end
  end

  rr_arbiter #(.N(N_VC), .PW(PTR_W)) u_rr_arbiter (
    .req   (eligible),
    .ptr   (ptr_q),
    .grant (rr_grant)
  );

`ifdef VC_SCHED_LOCK_EN
  localparam int BCNT_W = $clog2(BURST_LEN + 1);

  logic [PTR_W-1:0]  lock_vc_q, lock_vc_d;
  logic [BCNT_W-1:0] burst_q, burst_d;
  logic              lock_hit;

  // The locked VC jumps the round-robin queue until it runs dry or uses up its burst.
  always_comb begin
    lock_hit  = (state_q == SEND) && eligible[lock_vc_q] &&
                (burst_q < BCNT_W'(BURST_LEN));
    sel_grant = rr_grant;
    if (lock_hit) begin
      sel_grant            = '0;
      sel_grant[lock_vc_q] = 1'b1;
    end
  end

  always_comb begin
    lock_vc_d = lock_vc_q;
    burst_d   = burst_q;
    if (grant_any) begin
      if (lock_hit) begin
        burst_d = burst_q + BCNT_W'(1);
      end else begin
        lock_vc_d = grant_idx;
        burst_d   = BCNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!arst) begin
      lock_vc_q <= '0;
      burst_q   <= '0;
    end else begin
      lock_vc_q <= lock_vc_d;
      burst_q   <= burst_d;
    end
  end
`else
  assign sel_grant = rr_grant;
`endif

  always_comb begin
    // No pops may escape while reset is held.
    grant     = arst ? sel_grant : '0;
    grant_any = |grant;
    grant_idx = '0;
    pay_sel   = '0;
    for (int k = 0; k < N_VC; k++) begin
      if (grant[k]) begin
        grant_idx = PTR_W'(k);
        pay_sel   = bus.vc_req_i[k*FLIT_W + DATA_LSB +: PAY_W];
      end
    end

    fout_d = '0;
    if (grant_any) begin
      fout_d[VLD_BIT]                = 1'b1;
      fout_d[VC_MSB:VC_LSB]          = VC_W'(grant_idx);
      fout_d[FLIT_W-1:DATA_LSB]      = pay_sel;
    end

    err_d    = err_q;
    credit_d = credit_q;
    for (int k = 0; k < N_VC; k++) begin
      if (grant[k] && !bus.credit_ret_i[k]) begin
        credit_d[k] = credit_q[k] - CRED_W'(1);
      end else if (!grant[k] && bus.credit_ret_i[k]) begin
        if (credit_q[k] == CRED_W'(BUF_DEPTH)) begin
          err_d = 1'b1;
        end else begin
          credit_d[k] = credit_q[k] + CRED_W'(1);
        end
      end
    end

    ptr_d = ptr_q;
    if (grant_any) begin
      ptr_d = (grant_idx == PTR_W'(N_VC - 1)) ? '0 : grant_idx + PTR_W'(1);
    end

    state_d = grant_any ? SEND : IDLE;
  end

  always_ff @(posedge clk) begin
    if (!arst) begin
      for (int k = 0; k < N_VC; k++) begin
        credit_q[k] <= CRED_W'(BUF_DEPTH);
      end
      ptr_q   <= '0;
      fout_q  <= '0;
      err_q   <= 1'b0;
      state_q <= IDLE;
    end else begin
      credit_q <= credit_d;
      ptr_q    <= ptr_d;
      fout_q   <= fout_d;
      err_q    <= err_d;
      state_q  <= state_d;
    end
  end

  assign bus.vc_ready_o   = grant;
  assign bus.fout_req_o   = fout_q;
  assign bus.credit_cnt_o = credit_q;
  assign bus.credit_err_o = err_q;
  assign bus.state_o      = state_q;

endmodule

// File: tb/tb_vc_output_scheduler.sv
// Randomised and directed bench for vc_output_scheduler against an integer reference model.
module tb_vc_output_scheduler;
  import noc_pkg::*;

  localparam int NV    = 3;
  localparam int FW    = 37;
  localparam int DW    = FW - 3;
  localparam int BL    = 4;
  localparam int DEPTH = 4;
`ifdef VC_SCHED_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic clk  = 1'b0;
  logic arst = 1'b0;
  always #5 clk = ~clk;

  vc_output_scheduler_if #(.NV(NV), .FW(FW)) bus ();

  vc_output_scheduler dut (
    .clk  (clk),
    .arst (arst),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [NV-1:0] vld;
  logic [NV-1:0] ret;
  logic [DW-1:0] pay [NV];

  int          m_cred [NV];
  int          m_ptr;
  bit          m_err;
  logic [FW-1:0] m_fout;
  bit          m_send;
  int          m_lock;
  int          m_burst;

  logic [NV-1:0]   exp_ready, obs_ready;
  logic [FW-1:0]   obs_fout;
  logic [NV*3-1:0] obs_cred, exp_cred;
  logic            obs_err;

  function automatic bit elig(int k);
    return vld[k] && (m_cred[k] > 0);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NV; k++) m_cred[k] = DEPTH;
    m_ptr   = 0;
    m_err   = 1'b0;
    m_fout  = '0;
    m_send  = 1'b0;
    m_lock  = 0;
    m_burst = 0;
  endtask

  task automatic rand_pay();
    for (int k = 0; k < NV; k++) pay[k] = DW'({$urandom(), $urandom()});
  endtask

  // Drive one cycle, predict the grant, then advance the model past the clock edge.
  task automatic step();
    int   g;
    flit_t f;
    for (int k = 0; k < NV; k++) begin
      f.data  = pay[k];
      f.vc_id = 2'($urandom_range(0, 3));
      f.vld   = vld[k];
      bus.vc_req_i[k*FW +: FW] = f;
    end
    bus.credit_ret_i = ret;
    #1;
    g = -1;
    if (arst) begin
      if (LOCK && m_send && elig(m_lock) && m_burst < BL) g = m_lock;
      else begin
        for (int i = 0; i < NV; i++) begin
          if (g < 0 && elig((m_ptr + i) % NV)) g = (m_ptr + i) % NV;
        end
      end
    end
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    obs_ready = bus.vc_ready_o;
    @(posedge clk);
    #1;
    if (!arst) model_reset();
    else begin
      m_fout = '0;
      if (g >= 0) m_fout = {pay[g], 2'(g), 1'b1};
      for (int k = 0; k < NV; k++) begin
        if (ret[k] && g != k) begin
          if (m_cred[k] == DEPTH) m_err = 1'b1;
          else m_cred[k]++;
        end else if (!ret[k] && g == k) begin
          m_cred[k]--;
        end
      end
      if (g >= 0) begin
        if (LOCK && m_send && g == m_lock && m_burst < BL) m_burst++;
        else begin
          m_lock  = g;
          m_burst = 1;
        end
        m_ptr = (g + 1) % NV;
      end
      m_send = (g >= 0);
    end
    for (int k = 0; k < NV; k++) exp_cred[k*3 +: 3] = 3'(m_cred[k]);
    obs_fout = bus.fout_req_o;
    obs_cred = bus.credit_cnt_o;
    obs_err  = bus.credit_err_o;
  endtask

  task automatic do_reset();
    arst = 1'b0;
    vld  = '0;
    ret  = '0;
    step();
    arst = 1'b1;
  endtask

  task automatic test_reset();
    arst = 1'b0;
    vld  = '1;
    ret  = '0;
    for (int i = 0; i < 3; i++) begin
      rand_pay();
      step();
      checks++;
      if (obs_ready !== 3'b000) begin
        errors++;
        $display("FAIL reset_ready[%0d]: got %b expected 000", i, obs_ready);
      end
    end
    checks++;
    if (obs_fout !== '0) begin
      errors++;
      $display("FAIL reset_fout: got %h expected 0", obs_fout);
    end
    checks++;
    if (obs_cred !== {3'd4, 3'd4, 3'd4}) begin
      errors++;
      $display("FAIL reset_credits: got %o expected 444", obs_cred);
    end
    checks++;
    if (obs_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_err: got %b expected 0", obs_err);
    end
    arst = 1'b1;
  endtask

  task automatic test_credit_exhaust();
    logic [NV-1:0] tbl [9] = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b000,
                               3'b000, 3'b000, 3'b010, 3'b000};
    do_reset();
    vld = 3'b010;
    for (int i = 0; i < 9; i++) begin
      ret = (i == 6) ? 3'b010 : 3'b000;
      rand_pay();
      step();
      checks++;
      if (obs_ready !== tbl[i]) begin
        errors++;
        $display("FAIL exhaust_ready[%0d]: got %b expected %b", i, obs_ready, tbl[i]);
      end
      checks++;
      if (obs_fout !== ((tbl[i] != 0) ? {pay[1], 2'd1, 1'b1} : {FW{1'b0}})) begin
        errors++;
        $display("FAIL exhaust_fout[%0d]: got %h expected vc1 flit=%0d", i, obs_fout, tbl[i] != 0);
      end
    end
  endtask

  task automatic test_fairness();
    int ord [6] = '{0, 1, 2, 0, 1, 2};
    do_reset();
    vld = 3'b111;
    ret = 3'b000;
    for (int i = 0; i < 6; i++) begin
      rand_pay();
      step();
      checks++;
      if (obs_ready !== (3'b001 << ord[i])) begin
        errors++;
        $display("FAIL fair_ready[%0d]: got %b expected vc%0d", i, obs_ready, ord[i]);
      end
      checks++;
      if (obs_fout !== {pay[ord[i]], 2'(ord[i]), 1'b1}) begin
        errors++;
        $display("FAIL fair_fout[%0d]: got %h expected %h", i, obs_fout,
                 {pay[ord[i]], 2'(ord[i]), 1'b1});
      end
    end
  endtask

  task automatic test_simul_grant_return();
    do_reset();
    vld = 3'b001;
    ret = 3'b000;
    step();
    step();
    ret = 3'b001;
    step();
    checks++;
    if (obs_ready !== 3'b001) begin
      errors++;
      $display("FAIL simul_ready: got %b expected 001", obs_ready);
    end
    checks++;
    if (obs_cred[2:0] !== 3'd2) begin
      errors++;
      $display("FAIL simul_credit: got %0d expected 2", obs_cred[2:0]);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    vld = 3'b000;
    ret = 3'b100;
    step();
    checks++;
    if (obs_cred[8:6] !== 3'd4) begin
      errors++;
      $display("FAIL ovf_credit: got %0d expected 4", obs_cred[8:6]);
    end
    ret = 3'b000;
    for (int i = 0; i < 5; i++) begin
      vld = NV'($urandom_range(0, 7));
      rand_pay();
      step();
      checks++;
      if (obs_err !== 1'b1) begin
        errors++;
        $display("FAIL ovf_sticky[%0d]: got %b expected 1", i, obs_err);
      end
    end
    arst = 1'b0;
    step();
    arst = 1'b1;
    checks++;
    if (obs_err !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear: got %b expected 0", obs_err);
    end
  endtask

  task automatic test_lock();
    int lk [8] = '{0, 0, 0, 0, 1, 1, 1, 1};
    int rr [8] = '{0, 1, 0, 1, 0, 1, 0, 1};
    int e;
    do_reset();
    vld = 3'b011;
    ret = 3'b000;
    for (int i = 0; i < 8; i++) begin
      rand_pay();
      step();
      e = LOCK ? lk[i] : rr[i];
      checks++;
      if (obs_ready !== (3'b001 << e)) begin
        errors++;
        $display("FAIL lock_order[%0d]: got %b expected vc%0d", i, obs_ready, e);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      arst = ($urandom_range(0, 49) != 0);
      vld  = NV'($urandom_range(0, 7));
      for (int k = 0; k < NV; k++) ret[k] = ($urandom_range(0, 3) == 0);
      rand_pay();
      step();
      checks++;
      if (obs_ready !== exp_ready) begin
        errors++;
        $display("FAIL rand_ready[%0d]: got %b expected %b", i, obs_ready, exp_ready);
      end
      checks++;
      if (obs_fout !== m_fout) begin
        errors++;
        $display("FAIL rand_fout[%0d]: got %h expected %h", i, obs_fout, m_fout);
      end
      checks++;
      if (obs_cred !== exp_cred) begin
        errors++;
        $display("FAIL rand_credit[%0d]: got %o expected %o", i, obs_cred, exp_cred);
      end
      checks++;
      if (obs_err !== m_err) begin
        errors++;
        $display("FAIL rand_err[%0d]: got %b expected %b", i, obs_err, m_err);
      end
    end
    arst = 1'b1;
  endtask

  initial begin
    model_reset();
    vld = '0;
    ret = '0;
    rand_pay();
    bus.vc_req_i     = '0;
    bus.credit_ret_i = '0;
    test_reset();
    test_credit_exhaust();
    test_fairness();
    test_simul_grant_return();
    test_overflow();
    test_lock();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
